pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
// Program-counter and fetch sequencer directly downstream of the branch decision stage.
// Consumes the registered branch-taken select plus branch/jump targets and maintains the PC.
// Issues instruction-memory fetch requests and generates a one-cycle pipeline flush on every redirect.
// Handles stall, memory back-pressure and the HALT instruction.
// PARAMETERS
// PC_W       16         PC / target width in bits
// RESET_VEC  16'h0000   PC value loaded on reset (PC_W bits)
// CNT_W      16         width of taken-branch counter (used only with TAKEN_CNT_EN)
// PORTS
// clk         in   1      system clock, all state on posedge
// rst         in   1      asynchronous, active-high reset
// br_valid    in   1      a branch opcode resolves this cycle
// branch_sel  in   1      branch taken (pc_branch_sel_out of branch logic); qualified by br_valid
// br_target   in   PC_W   branch destination
// jmp_en      in   1      unconditional jump resolves this cycle
// jmp_target  in   PC_W   jump destination
// halt        in   1      HALT instruction resolved this cycle
// stall       in   1      downstream hazard stall; hold PC
// imem_rdy    in   1      instruction memory accepts fetch_req this cycle
// pc          out  PC_W   current fetch address (registered)
// pc_plus1    out  PC_W   pc+1 mod 2^PC_W (combinational from pc)
// fetch_req   out  1      fetch request to instruction memory (registered)
// flush       out  1      one-cycle squash of younger in-flight instructions (registered)
// halted      out  1      sequencer stopped (registered)
// taken_cnt   out  CNT_W  taken-branch count; present only with TAKEN_CNT_EN
// BEHAVIOUR
// - Reset (async, immediate, also mid-operation):
//   - pc=RESET_VEC, fetch_req=0, flush=0, halted=0, taken_cnt=0, state=IDLE.
// - States: IDLE, RUN, HALTED.
//   - IDLE: one cycle after rst deasserts. All inputs ignored. Moves to RUN. fetch_req=1 from the first RUN cycle.
//   - RUN: next-PC priority, highest first:
//     1) br_valid&branch_sel -> pc<=br_target
//     2) jmp_en -> pc<=jmp_target
//     3) halt -> go to HALTED, pc held
//     4) stall | !imem_rdy -> pc held
//     5) otherwise pc<=pc+1
//   - Redirect (1 or 2) overrides stall, imem_rdy and halt. A halt in the same cycle is squashed.
//   - branch_sel with br_valid=0 is ignored.
//   - HALTED: pc frozen, fetch_req=0, halted=1. Exit only via rst.
// - flush=1 in exactly the cycle after a redirect is accepted, coinciding with the new pc. Otherwise 0.
//   - Back-to-back redirects give back-to-back flush cycles.
// - fetch_req stays 1 throughout RUN while imem_rdy=0, with pc stable. Request accepted when fetch_req&imem_rdy.
// - Arithmetic: pc+1 wraps from all-ones to 0; no overflow flag. Targets used unmodified, full PC_W.
// - Latency: the redirect decision cycle is N; the new pc and flush are visible at N+1.
// CONFIGURATION
// - Macro TAKEN_CNT_EN.
// - Defined:
//   - Port taken_cnt is present.
//   - Increments by 1 for every accepted branch redirect, priority 1 only; jumps excluded.
//   - Saturates at all-ones; reset to 0.
// - Undefined: port taken_cnt and its register are absent. All other behaviour is identical.
// TESTING
// - Reset: rst=1 mid-run at pc=16'h0042 -> same cycle pc=16'h0000, fetch_req=0, flush=0, halted=0.
//   After release: IDLE 1 cycle, then fetch_req=1, pc increments 0,1,2 with imem_rdy=1.
// - Taken branch: pc=16'h0010, br_valid=1, branch_sel=1, br_target=16'h0200, stall=1 -> next cycle pc=16'h0200, flush=1.
//   Following cycle flush=0. Not taken (branch_sel=0) -> pc=16'h0011, flush=0.
// - Priority: br_valid=1, branch_sel=1, br_target=16'h0300, jmp_en=1, jmp_target=16'h0400, halt=1 -> pc=16'h0300, halted=0.
//   Jump alone -> pc=16'h0400, flush=1, taken_cnt unchanged.
// - Back-pressure: imem_rdy=0 for 3 cycles at pc=16'h0020 -> pc holds 16'h0020, fetch_req=1.
//   imem_rdy=1 -> pc=16'h0021.
// - Wrap/halt: pc=16'hFFFF, no events -> pc=16'h0000. halt=1 -> halted=1, fetch_req=0.
//   Branch inputs afterwards leave pc unchanged until rst.
// - TAKEN_CNT_EN (CNT_W=2): 5 taken branches -> taken_cnt 1,2,3,3,3. br_valid=1 with branch_sel=0 -> no increment.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter and instruction-fetch sequencer.
// Sits behind the branch decision stage. Maintains the PC, issues fetch
// requests, flushes younger instructions on redirects and stops on HALT.
// Optional feature: define TAKEN_CNT_EN to add a saturating taken-branch
// counter on o_taken_cnt.
module pc_fetch_sequencer #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_br_valid,
  input  logic            i_branch_sel,
  input  logic [PC_W-1:0] i_br_target,
  input  logic            i_jmp_en,
  input  logic [PC_W-1:0] i_jmp_target,
  input  logic            i_halt,
  input  logic            i_stall,
  input  logic            i_imem_rdy,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_pc_plus1,
  output logic            o_fetch_req,
  output logic            o_flush,
  output logic            o_halted
`ifdef TAKEN_CNT_EN
  ,
  output logic [CNT_W-1:0] o_taken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_req;
  logic            r_flush;
  logic            r_halted;
  logic [PC_W-1:0] w_pc_plus1;
  logic            w_br_taken;

  // Reject a zero-width counter configuration at elaboration.
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("pc_fetch_sequencer: CNT_W must be nonzero");
  end

  assign w_pc_plus1 = r_pc + PC_W'(1);
  assign w_br_taken = i_br_valid & i_branch_sel;

  // Sequencer FSM: next-PC selection, fetch request, flush and halt flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VEC;
      r_fetch_req <= 1'b0;
      r_flush     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state     <= S_RUN;
          r_fetch_req <= 1'b1;
        end
        S_RUN: begin
          // Redirects win over halt, stall and memory back-pressure.
          if (w_br_taken) begin
            r_pc    <= i_br_target;
            r_flush <= 1'b1;
          end else if (i_jmp_en) begin
            r_pc    <= i_jmp_target;
            r_flush <= 1'b1;
          end else if (i_halt) begin
            r_state     <= S_HALTED;
            r_fetch_req <= 1'b0;
            r_halted    <= 1'b1;
          end else if (!i_stall && i_imem_rdy) begin
            r_pc <= w_pc_plus1;
          end
        end
        S_HALTED: begin
          r_fetch_req <= 1'b0;
          r_halted    <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TAKEN_CNT_EN
  logic [CNT_W-1:0] r_taken_cnt;

  // Saturating count of accepted taken-branch redirects (jumps excluded).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= '0;
    end else if ((r_state == S_RUN) && w_br_taken && (r_taken_cnt != '1)) begin
      r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign o_taken_cnt = r_taken_cnt;
`endif

  assign o_pc        = r_pc;
  assign o_pc_plus1  = w_pc_plus1;
  assign o_fetch_req = r_fetch_req;
  assign o_flush     = r_flush;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scenarios plus randomized run against a
// behavioural model of the PC sequencer. TAKEN_CNT_EN enables counter checks.
module tb_pc_fetch_sequencer;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic            clk;
  logic            rst;
  logic            i_br_valid;
  logic            i_branch_sel;
  logic [PC_W-1:0] i_br_target;
  logic            i_jmp_en;
  logic [PC_W-1:0] i_jmp_target;
  logic            i_halt;
  logic            i_stall;
  logic            i_imem_rdy;
  logic [PC_W-1:0] o_pc;
  logic [PC_W-1:0] o_pc_plus1;
  logic            o_fetch_req;
  logic            o_flush;
  logic            o_halted;
`ifdef TAKEN_CNT_EN
  logic [CNT_W-1:0] o_taken_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [PC_W-1:0] m_pc;
  logic            m_run;
  logic            m_halt;
  logic            m_fetch;
  logic            m_flush;
  int              m_cnt;

  pc_fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_VEC(16'h0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_br_valid  (i_br_valid),
    .i_branch_sel(i_branch_sel),
    .i_br_target (i_br_target),
    .i_jmp_en    (i_jmp_en),
    .i_jmp_target(i_jmp_target),
    .i_halt      (i_halt),
    .i_stall     (i_stall),
    .i_imem_rdy  (i_imem_rdy),
    .o_pc        (o_pc),
    .o_pc_plus1  (o_pc_plus1),
    .o_fetch_req (o_fetch_req),
    .o_flush     (o_flush),
    .o_halted    (o_halted)
`ifdef TAKEN_CNT_EN
    ,
    .o_taken_cnt (o_taken_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    i_br_valid   = 1'b0;
    i_branch_sel = 1'b0;
    i_br_target  = '0;
    i_jmp_en     = 1'b0;
    i_jmp_target = '0;
    i_halt       = 1'b0;
    i_stall      = 1'b0;
    i_imem_rdy   = 1'b1;
  endtask

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_run   = 1'b0;
    m_halt  = 1'b0;
    m_fetch = 1'b0;
    m_flush = 1'b0;
    m_cnt   = 0;
  endtask

  // Advance the model by one cycle from the present inputs, then clock the DUT.
  task automatic tick();
    if (m_halt) begin
      m_flush = 1'b0;
    end else if (!m_run) begin
      m_run   = 1'b1;
      m_fetch = 1'b1;
      m_flush = 1'b0;
    end else if (i_br_valid && i_branch_sel) begin
      m_pc    = i_br_target;
      m_flush = 1'b1;
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    end else if (i_jmp_en) begin
      m_pc    = i_jmp_target;
      m_flush = 1'b1;
    end else if (i_halt) begin
      m_halt  = 1'b1;
      m_fetch = 1'b0;
      m_flush = 1'b0;
    end else begin
      m_flush = 1'b0;
      if (!i_stall && i_imem_rdy) m_pc = 16'((int'(m_pc) + 1) % 65536);
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, release it after one edge; DUT then sits in IDLE.
  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic jump_to(input logic [PC_W-1:0] tgt);
    idle_inputs();
    i_jmp_en     = 1'b1;
    i_jmp_target = tgt;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if ({o_pc, o_fetch_req, o_flush, o_halted} !== {16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_init: got pc=%h fr=%b fl=%b h=%b, want 0000 0 0 0", o_pc, o_fetch_req, o_flush, o_halted);
    end
    rst = 1'b0;
    n_tests++;
    if (o_fetch_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_fetch: got %b want 0", o_fetch_req);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (o_fetch_req !== 1'b1 || o_pc !== 16'(k)) begin
        n_fail++;
        $display("FAIL reset_count%0d: got pc=%h fr=%b want pc=%h fr=1", k, o_pc, o_fetch_req, 16'(k));
      end
    end
    jump_to(16'h0042);
    n_tests++;
    if (o_pc !== 16'h0042 || o_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_pc: got pc=%h fl=%b want 0042 1", o_pc, o_flush);
    end
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_pc, o_fetch_req, o_flush, o_halted} !== {16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_async: got pc=%h fr=%b fl=%b h=%b, want 0000 0 0 0", o_pc, o_fetch_req, o_flush, o_halted);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_tests++;
    if (o_pc !== 16'h0000 || o_fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_restart: got pc=%h fr=%b want 0000 1", o_pc, o_fetch_req);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    tick();
    jump_to(16'h0010);
    i_br_valid   = 1'b1;
    i_branch_sel = 1'b1;
    i_br_target  = 16'h0200;
    i_stall      = 1'b1;
    tick();
    n_tests++;
    if (o_pc !== 16'h0200 || o_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_taken: got pc=%h fl=%b want 0200 1", o_pc, o_flush);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (o_pc !== 16'h0201 || o_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_after: got pc=%h fl=%b want 0201 0", o_pc, o_flush);
    end
    jump_to(16'h0010);
    i_br_valid  = 1'b1;
    i_br_target = 16'h0500;
    tick();
    n_tests++;
    if (o_pc !== 16'h0011 || o_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_not_taken: got pc=%h fl=%b want 0011 0", o_pc, o_flush);
    end
    idle_inputs();
    i_branch_sel = 1'b1;
    i_br_target  = 16'h0700;
    tick();
    n_tests++;
    if (o_pc !== 16'h0012 || o_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_unqualified: got pc=%h fl=%b want 0012 0", o_pc, o_flush);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    apply_reset();
    tick();
    i_br_valid   = 1'b1;
    i_branch_sel = 1'b1;
    i_br_target  = 16'h0300;
    i_jmp_en     = 1'b1;
    i_jmp_target = 16'h0400;
    i_halt       = 1'b1;
    tick();
    n_tests++;
    if (o_pc !== 16'h0300 || o_halted !== 1'b0 || o_flush !== 1'b1 || o_fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_branch: got pc=%h h=%b fl=%b fr=%b want 0300 0 1 1", o_pc, o_halted, o_flush, o_fetch_req);
    end
    jump_to(16'h0400);
    n_tests++;
    if (o_pc !== 16'h0400 || o_flush !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_jump: got pc=%h fl=%b want 0400 1", o_pc, o_flush);
    end
`ifdef TAKEN_CNT_EN
    n_tests++;
    if (o_taken_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_jump_cnt: got %0d want 1", o_taken_cnt);
    end
`endif
  endtask

  task automatic test_back_pressure();
    apply_reset();
    tick();
    jump_to(16'h0020);
    i_imem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (o_pc !== 16'h0020 || o_fetch_req !== 1'b1 || o_flush !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got pc=%h fr=%b fl=%b want 0020 1 0", k, o_pc, o_fetch_req, o_flush);
      end
    end
    i_imem_rdy = 1'b1;
    tick();
    n_tests++;
    if (o_pc !== 16'h0021) begin
      n_fail++;
      $display("FAIL bp_release: got pc=%h want 0021", o_pc);
    end
  endtask

  task automatic test_wrap_halt();
    apply_reset();
    tick();
    jump_to(16'hFFFF);
    n_tests++;
    if (o_pc_plus1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_plus1: got %h want 0000", o_pc_plus1);
    end
    tick();
    n_tests++;
    if (o_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_pc: got %h want 0000", o_pc);
    end
    i_halt = 1'b1;
    tick();
    n_tests++;
    if (o_halted !== 1'b1 || o_fetch_req !== 1'b0 || o_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL halt_enter: got h=%b fr=%b pc=%h want 1 0 0000", o_halted, o_fetch_req, o_pc);
    end
    i_halt       = 1'b0;
    i_br_valid   = 1'b1;
    i_branch_sel = 1'b1;
    i_br_target  = 16'h1234;
    i_jmp_en     = 1'b1;
    i_jmp_target = 16'h5678;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (o_pc !== 16'h0000 || o_flush !== 1'b0 || o_halted !== 1'b1 || o_fetch_req !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_frozen%0d: got pc=%h fl=%b h=%b fr=%b want 0000 0 1 0", k, o_pc, o_flush, o_halted, o_fetch_req);
      end
    end
    idle_inputs();
  endtask

`ifdef TAKEN_CNT_EN
  task automatic test_taken_cnt();
    apply_reset();
    tick();
    n_tests++;
    if (o_taken_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL cnt_reset: got %0d want 0", o_taken_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      i_br_valid   = 1'b1;
      i_branch_sel = 1'b1;
      i_br_target  = 16'(16'h0100 + k);
      tick();
      n_tests++;
      if (o_taken_cnt !== 2'((k + 1 > 3) ? 3 : k + 1)) begin
        n_fail++;
        $display("FAIL cnt_step%0d: got %0d want %0d", k, o_taken_cnt, (k + 1 > 3) ? 3 : k + 1);
      end
    end
    i_branch_sel = 1'b0;
    tick();
    n_tests++;
    if (o_taken_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL cnt_not_taken: got %0d want 3", o_taken_cnt);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    tick();
    for (int k = 0; k < 800; k++) begin
      i_br_valid   = ($urandom_range(0, 3) == 0);
      i_branch_sel = 1'($urandom_range(0, 1));
      i_br_target  = 16'($urandom);
      i_jmp_en     = ($urandom_range(0, 7) == 0);
      i_jmp_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      i_halt       = ($urandom_range(0, 39) == 0);
      i_stall      = ($urandom_range(0, 3) == 0);
      i_imem_rdy   = ($urandom_range(0, 4) != 0);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) apply_reset();
      else tick();
      n_tests++;
      if ({o_pc, o_fetch_req, o_flush, o_halted} !== {m_pc, m_fetch, m_flush, m_halt}) begin
        n_fail++;
        $display("FAIL rand_state@%0d: got pc=%h fr=%b fl=%b h=%b want pc=%h fr=%b fl=%b h=%b",
                 k, o_pc, o_fetch_req, o_flush, o_halted, m_pc, m_fetch, m_flush, m_halt);
      end
      n_tests++;
      if (o_pc_plus1 !== 16'((int'(m_pc) + 1) % 65536)) begin
        n_fail++;
        $display("FAIL rand_plus1@%0d: got %h want %h", k, o_pc_plus1, 16'((int'(m_pc) + 1) % 65536));
      end
`ifdef TAKEN_CNT_EN
      n_tests++;
      if (o_taken_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt@%0d: got %0d want %0d", k, o_taken_cnt, m_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_branch();
    test_priority();
    test_back_pressure();
    test_wrap_halt();
`ifdef TAKEN_CNT_EN
    test_taken_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
